// File: rtl/mc_pc_unit.sv
// mc_pc_unit: registered program counter with a small return-address stack.
//   clk, rst_n           clock, asynchronous active-low reset
//   pc_we                PC write enable from the control FSM
//   pc_src               00 seq, 01 branch, 10 direct jump, 11 register jump
//   branch_off           signed word offset for branches
//   instr_idx            direct-jump instruction index
//   reg_target           register-jump target (rs value)
//   link                 push pc+4 on the RAS (jumps only)
//   ret                  register jump is a return; target comes from the RAS
//   pc                   current PC (registered)
//   pc_plus4             pc + 4 (combinational)
//   ras_empty, ras_full  RAS occupancy flags (registered)
//   ras_ovf              sticky: push while full
//   ras_miss             one-cycle pulse: return with an empty RAS
//   misalign             sticky: register target with nonzero low bits
module mc_pc_unit #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     IDX_W     = 26,
    parameter int unsigned     OFF_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_we,
    input  logic [1:0]       pc_src,
    input  logic [OFF_W-1:0] branch_off,
    input  logic [IDX_W-1:0] instr_idx,
    input  logic [PC_W-1:0]  reg_target,
    input  logic             link,
    input  logic             ret,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_miss,
    output logic             misalign
);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top, top_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [PC_W-1:0]  br_tgt, dir_tgt, jr_tgt, reg_aligned;
    logic signed [PC_W-1:0] off_ext;
    logic             is_jr, push, pop, miss_nxt, ovf_set, mis_set, cnt_empty, cnt_full;

    assign pc_plus4    = pc + PC_W'(4);
    assign off_ext     = PC_W'($signed(branch_off));
    assign br_tgt      = pc_plus4 + PC_W'(off_ext <<< 2);
    assign reg_aligned = {reg_target[PC_W-1:2], 2'b00};
    assign cnt_empty   = (cnt == '0);
    assign cnt_full    = (cnt == CNT_MAX);

    // Direct-jump target keeps the upper pc+4 bits, if any exist.
    generate
        if (PC_W == IDX_W + 2) begin : g_dir_full
            assign dir_tgt = {instr_idx, 2'b00};
        end else begin : g_dir_region
            assign dir_tgt = {pc_plus4[PC_W-1:IDX_W+2], instr_idx, 2'b00};
        end
    endgenerate

    assign is_jr    = pc_we && (pc_src == 2'b11);
    assign pop      = is_jr && ret && !cnt_empty;
    assign push     = pc_we && link && pc_src[1];
    assign jr_tgt   = pop ? ras_mem[top] : reg_aligned;
    assign miss_nxt = is_jr && ret && cnt_empty;
    assign mis_set  = is_jr && !pop && (reg_target[1:0] != 2'b00);
    assign ovf_set  = push && !pop && cnt_full;

    // Next PC and RAS pointer/count.
    always_comb begin
        pc_nxt  = pc;
        top_nxt = top;
        cnt_nxt = cnt;
        if (pc_we) begin
            unique case (pc_src)
                2'b00:   pc_nxt = pc_plus4;
                2'b01:   pc_nxt = br_tgt;
                2'b10:   pc_nxt = dir_tgt;
                default: pc_nxt = jr_tgt;
            endcase
        end
        // Linked return replaces the top in place: no pointer/count change.
        if (push && !pop) begin
            top_nxt = top + PTR_W'(1);
            if (!cnt_full) cnt_nxt = cnt + CNT_W'(1);
        end else if (pop && !push) begin
            top_nxt = top - PTR_W'(1);
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            top       <= '0;
            cnt       <= '0;
            ras_empty <= 1'b1;
            ras_full  <= 1'b0;
            ras_ovf   <= 1'b0;
            ras_miss  <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            top       <= top_nxt;
            cnt       <= cnt_nxt;
            ras_empty <= (cnt_nxt == '0);
            ras_full  <= (cnt_nxt == CNT_MAX);
            ras_miss  <= miss_nxt;
            if (ovf_set) ras_ovf  <= 1'b1;
            if (mis_set) misalign <= 1'b1;
        end
    end

    // RAS storage is not reset; entries are only read when count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            if (pop) ras_mem[top] <= pc_plus4;
            else     ras_mem[top + PTR_W'(1)] <= pc_plus4;
        end
    end
endmodule

// File: tb/tb_mc_pc_unit.sv
module tb_mc_pc_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_we = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [15:0] branch_off = '0;
    logic [25:0] instr_idx = '0;
    logic [31:0] reg_target = '0;
    logic        link = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        ras_empty, ras_full, ras_ovf, ras_miss, misalign;

    int tests = 0;
    int fails = 0;

    mc_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_we(pc_we), .pc_src(pc_src),
        .branch_off(branch_off), .instr_idx(instr_idx), .reg_target(reg_target),
        .link(link), .ret(ret), .pc(pc), .pc_plus4(pc_plus4),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
        .ras_miss(ras_miss), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at negedge, sample 1 time unit after posedge.
    task automatic step(input logic we, input logic [1:0] src, input logic [15:0] off,
                        input logic [25:0] idx, input logic [31:0] rt,
                        input logic lk, input logic rr);
        @(negedge clk);
        pc_we = we; pc_src = src; branch_off = off; instr_idx = idx;
        reg_target = rt; link = lk; ret = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] held;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_ovf", 32'(ras_ovf), 32'd0);
        chk("rst_miss", 32'(ras_miss), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential
        step(1, 2'b00, 16'h0, 26'h0, 32'h0, 0, 0); chk("seq1", pc, 32'h4);
        step(1, 2'b00, 16'h0, 26'h0, 32'h0, 0, 0); chk("seq2", pc, 32'h8);
        step(1, 2'b00, 16'h0, 26'h0, 32'h0, 0, 0); chk("seq3", pc, 32'hC);
        chk("seq_empty", 32'(ras_empty), 32'd1);
        chk("seq_plus4", pc_plus4, 32'h10);

        // Branches; link/ret on a branch must have no effect
        step(1, 2'b11, 16'h0, 26'h0, 32'h100, 0, 0); chk("jr100", pc, 32'h100);
        step(1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 1, 1); chk("br_neg", pc, 32'h0FC);
        chk("br_link_empty", 32'(ras_empty), 32'd1);
        chk("br_ret_miss", 32'(ras_miss), 32'd0);
        step(1, 2'b01, 16'h0003, 26'h0, 32'h0, 0, 0); chk("br_pos", pc, 32'h10C);

        // Direct jump and link, then return
        step(1, 2'b11, 16'h0, 26'h0, 32'h4000_0010, 0, 0); chk("jr_4000", pc, 32'h4000_0010);
        step(1, 2'b10, 16'h0, 26'h40, 32'h0, 1, 0); chk("jal", pc, 32'h4000_0100);
        chk("jal_empty", 32'(ras_empty), 32'd0);
        step(1, 2'b11, 16'h0, 26'h0, 32'hDEAD_BEEF, 0, 1); chk("ret1", pc, 32'h4000_0014);
        chk("ret1_empty", 32'(ras_empty), 32'd1);
        chk("ret1_mis", 32'(misalign), 32'd0);
        step(1, 2'b11, 16'h0, 26'h0, 32'hDEAD_BEEF, 0, 1); chk("ret2", pc, 32'hDEAD_BEEC);
        chk("ret2_miss", 32'(ras_miss), 32'd1);
        chk("ret2_mis", 32'(misalign), 32'd1);
        step(0, 2'b00, 16'h0, 26'h0, 32'h0, 0, 0);
        chk("miss_pulse_end", 32'(ras_miss), 32'd0);
        chk("idle_pc", pc, 32'hDEAD_BEEC);

        // Overflow: five linked jumps into a 4-entry RAS
        step(1, 2'b11, 16'h0, 26'h0, 32'h1000, 0, 0); chk("jr1000", pc, 32'h1000);
        for (int k = 2; k <= 6; k++) begin
            step(1, 2'b11, 16'h0, 26'h0, 32'(k) << 12, 1, 0);
            chk("jalr", pc, 32'(k) << 12);
            if (k == 5) begin
                chk("full4", 32'(ras_full), 32'd1);
                chk("ovf4", 32'(ras_ovf), 32'd0);
            end
        end
        chk("full5", 32'(ras_full), 32'd1);
        chk("ovf5", 32'(ras_ovf), 32'd1);
        for (int k = 5; k >= 2; k--) begin
            step(1, 2'b11, 16'h0, 26'h0, 32'h0, 0, 1);
            chk("ovf_ret", pc, (32'(k) << 12) + 32'h4);
            chk("ovf_ret_full", 32'(ras_full), 32'd0);
        end
        chk("ovf_drained", 32'(ras_empty), 32'd1);
        step(1, 2'b11, 16'h0, 26'h0, 32'h7001, 0, 1); chk("ret_miss_pc", pc, 32'h7000);
        chk("ret_miss", 32'(ras_miss), 32'd1);

        // Linked return replaces the top entry in place
        step(1, 2'b11, 16'h0, 26'h0, 32'h8000, 1, 0); chk("jalr8000", pc, 32'h8000);
        step(1, 2'b11, 16'h0, 26'h0, 32'h0, 1, 1); chk("lret_pc", pc, 32'h7004);
        chk("lret_empty", 32'(ras_empty), 32'd0);
        chk("lret_miss", 32'(ras_miss), 32'd0);
        step(1, 2'b11, 16'h0, 26'h0, 32'h0, 0, 1); chk("lret_pop", pc, 32'h8004);
        chk("lret_pop_empty", 32'(ras_empty), 32'd1);

        // Hold with random inputs
        held = pc;
        for (int i = 0; i < 5; i++) begin
            step(0, 2'($urandom), 16'($urandom), 26'($urandom), $urandom, 1'($urandom), 1'($urandom));
            chk("hold_pc", pc, held);
            chk("hold_empty", 32'(ras_empty), 32'd1);
        end
        chk("pre_rst_ovf", 32'(ras_ovf), 32'd1);

        // Async reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_ovf", 32'(ras_ovf), 32'd0);
        chk("arst_mis", 32'(misalign), 32'd0);
        chk("arst_empty", 32'(ras_empty), 32'd1);
        chk("arst_full", 32'(ras_full), 32'd0);
        chk("arst_miss", 32'(ras_miss), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_pc_unit.md
# mc_pc_unit

Registered program-counter unit for the multicycle CPU, the parametrised successor of the combinational direct-jump target former. It holds the architectural PC and, on each control-unit PC write, selects among sequential, branch, direct-jump and register-jump targets. A small return-address stack (RAS) lets returns take their target from a prediction buffer rather than the register file. It sits between the control FSM (`pc_we`, `pc_src`, `link`, `ret`) and the instruction-fetch address port.

## Interface
- `PC_W`, default 32: PC width. Must satisfy `PC_W >= IDX_W + 2`.
- `IDX_W`, default 26: direct-jump instruction-index width.
- `OFF_W`, default 16: branch offset width (word offset).
- `RESET_PC`, default 0: PC value after reset.
- `RAS_DEPTH`, default 4: return-address stack entries (power of two, ≥2).

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pc_we`  in  1  PC write enable from control FSM
- `pc_src`  in  2  next-PC select: 00 sequential, 01 branch, 10 direct jump, 11 register jump
- `branch_off`  in  OFF_W  signed word offset
- `instr_idx`  in  IDX_W  direct-jump index
- `reg_target`  in  PC_W  register-jump target (rs value)
- `link`  in  1  push pc+4 onto RAS (honoured only for `pc_src` 10/11)
- `ret`  in  1  register jump is a return: take target from RAS
- `pc`  out  PC_W  current PC (registered)
- `pc_plus4`  out  PC_W  `pc + 4` (combinational from `pc`)
- `ras_empty`  out  1  RAS count == 0 (registered)
- `ras_full`  out  1  RAS count == RAS_DEPTH (registered)
- `ras_ovf`  out  1  sticky: a push occurred while full
- `ras_miss`  out  1  one-cycle pulse: `ret` with an empty RAS
- `misalign`  out  1  sticky: register-jump target with nonzero bits [1:0]

## Operation
- Targets, all PC_W wide, with arithmetic modulo 2^PC_W:
  - seq = `pc + 4`
  - br = `pc + 4 + (sign_extend(branch_off) << 2)`
  - dir = `{pc_plus4[PC_W-1:IDX_W+2], instr_idx, 2'b00}`. When `PC_W == IDX_W+2` there are no upper bits.
  - jr = `ret && !ras_empty` ? RAS top : `{reg_target[PC_W-1:2], 2'b00}`
- When `pc_we` = 1, `pc` <= the selected target. When `pc_we` = 0, all state holds and `link`/`ret` are ignored.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push (`pc_we && link && pc_src[1]`): write `pc + 4` at top+1 and advance top. If full, the oldest entry is overwritten, count stays at RAS_DEPTH, and `ras_ovf` is set.
  - Pop (`pc_we && pc_src==11 && ret && !ras_empty`): the target is the top entry; top retreats and count decrements.
  - Pop and push in the same write (linked return): the top entry is replaced by the new `pc + 4`; count and pointer are unchanged.
  - `ret` on an empty RAS: the target falls back to aligned `reg_target`, `ras_miss` pulses for one cycle, and the RAS is unchanged. A push in that same write still proceeds.
- `link` or `ret` with `pc_src` 00/01 has no effect.
- `misalign` is set when `pc_we && pc_src==11` and the target is taken from `reg_target` with bits [1:0] ≠ 0. The PC is still written with the aligned value.
- Sticky flags clear only on reset.

## Timing
- Reset (async assert, released synchronously to `clk` by the top level) gives: `pc`=RESET_PC, RAS count=0, top=0, `ras_empty`=1, `ras_full`=0, `ras_ovf`=0, `ras_miss`=0, `misalign`=0. RAS entries are not cleared.
- Latency is one cycle: inputs sampled at edge N with `pc_we`=1 appear on `pc` after edge N. `pc_plus4` follows `pc` combinationally.
- Flags update at the same edge as the PC write they describe. `ras_miss` is high for exactly the following cycle.
- Reset asserted mid-operation immediately forces the reset values, regardless of `clk`.
- No handshake: the control FSM guarantees input stability at the sampling edge.

## Test plan
- Reset then sequential: release `rst_n`, then 3 writes with `pc_src`=00 -> `pc` 0x0, 0x4, 0x8, 0xC; `ras_empty`=1.
- Branch: `pc`=0x100, `branch_off`=0xFFFE, `pc_src`=01 -> `pc`=0x0FC. Then `branch_off`=0x0003 -> `pc`=0x10C.
- Direct jump and link: `pc`=0x4000_0010, `instr_idx`=0x0000040, `pc_src`=10, `link`=1 -> `pc`=0x4000_0100, RAS top=0x4000_0014, `ras_empty`=0.
- Return: continuing, `pc_src`=11, `ret`=1, `reg_target`=0xDEAD_BEEF -> `pc`=0x4000_0014, `ras_empty`=1. A second `ret` -> `pc`=0xDEAD_BEEC, `ras_miss` pulses, `misalign`=1.
- Overflow: 5 linked jumps with RAS_DEPTH=4 -> `ras_full`=1, `ras_ovf`=1. Four returns yield link addresses 5, 4, 3, 2 in that order, then `ras_empty`=1.
- Hold and async reset: `pc_we`=0 with random inputs -> `pc` unchanged. Assert `rst_n`=0 between edges -> `pc`=RESET_PC immediately and all flags cleared.
